// File: rtl/wb_stage_pipe_if.sv
// MEM -> WB stage bus: entry valid/allowin handshake plus every field the
// writeback stage latches from the memory stage.
interface wb_stage_pipe_if;
  logic        ms2ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        ms_csr_re;
  logic        ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask;
  logic [31:0] ms_csr_wvalue;
  logic [31:0] ms_badv;
  logic [7:0]  ms_exc;
  logic        ms_ertn;

  // Memory stage side: offers entries, observes allowin.
  modport master (
    output ms2ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_csr_re, ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
           ms_badv, ms_exc, ms_ertn,
    input  ws_allowin
  );

  // Writeback stage side: consumes entries, drives allowin.
  modport slave (
    input  ms2ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_csr_re, ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
           ms_badv, ms_exc, ms_ertn,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Writeback stage: holds one retiring instruction, waits out the CSR read
// latency when needed, then commits register/CSR writes or raises the
// exception / ertn flush in a single READY cycle.
module wb_stage_pipe #(
  parameter int unsigned CSR_LAT = 0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              resetn,
  wb_stage_pipe_if.slave    ms,
  output logic              csr_re,
  output logic [13:0]       csr_num,
  input  logic [31:0]       csr_rvalue,
  output logic              csr_we,
  output logic [31:0]       csr_wmask,
  output logic [31:0]       csr_wvalue,
  output logic              wb_ex,
  output logic              ertn_flush,
  output logic [31:0]       wb_pc,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [31:0]       wb_badv,
  output logic              ws_rf_we,
  output logic [4:0]        ws_rf_waddr,
  output logic [31:0]       ws_rf_wdata,
  output logic              ws_fwd_pending,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  // Countdown start: the entry spends CSR_LAT cycles in WAIT (count CSR_LAT-1 .. 0).
  localparam logic [1:0] WAIT_INIT = (CSR_LAT > 0) ? 2'(CSR_LAT - 1) : 2'd0;
  localparam logic       CSR_DIRECT = (CSR_LAT == 0);

  state_t            state_q;
  logic [1:0]        wait_cnt_q;
  logic [31:0]       pc_q;
  logic              rf_we_q;
  logic [4:0]        rf_waddr_q;
  logic [31:0]       data_q;
  logic              csr_re_q;
  logic              csr_we_q;
  logic [13:0]       csr_num_q;
  logic [31:0]       csr_wmask_q;
  logic [31:0]       csr_wvalue_q;
  logic [31:0]       badv_q;
  logic [7:0]        exc_q;
  logic              ertn_q;
  logic [CNT_W-1:0]  retire_q;

  logic ws_valid;
  logic ready;
  logic exc_none;
  logic accept;
  logic go_wait;
  logic badv_sel;

  assign ws_valid = (state_q != S_EMPTY);
  assign ready    = (state_q == S_READY);
  assign exc_none = (exc_q == 8'd0);

  assign wb_ex      = ready & ~exc_none;
  assign ertn_flush = ready & ertn_q & exc_none;

  // A flushing commit blocks the incoming entry; a clean commit frees the slot.
  assign ms.ws_allowin = ((state_q == S_EMPTY) | ready) & ~wb_ex & ~ertn_flush;
  assign accept        = ms.ms2ws_valid & ms.ws_allowin;
  assign go_wait       = ms.ms_csr_re & (ms.ms_exc == 8'd0) & ~CSR_DIRECT;

  // Stage state machine, entry latches and retire counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_EMPTY;
      wait_cnt_q   <= 2'd0;
      pc_q         <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      data_q       <= '0;
      csr_re_q     <= 1'b0;
      csr_we_q     <= 1'b0;
      csr_num_q    <= '0;
      csr_wmask_q  <= '0;
      csr_wvalue_q <= '0;
      badv_q       <= '0;
      exc_q        <= '0;
      ertn_q       <= 1'b0;
      retire_q     <= '0;
    end else begin
      if (ready & exc_none) begin
        retire_q <= retire_q + 1'b1;
      end
      case (state_q)
        S_WAIT: begin
          if (wait_cnt_q == 2'd0) begin
            state_q <= S_READY;
            data_q  <= csr_rvalue;
          end else begin
            wait_cnt_q <= wait_cnt_q - 2'd1;
          end
        end
        S_READY: state_q <= S_EMPTY;
        default: state_q <= S_EMPTY;
      endcase
      // Accept only happens from EMPTY/READY, so it never collides with WAIT updates.
      if (accept) begin
        state_q      <= go_wait ? S_WAIT : S_READY;
        wait_cnt_q   <= WAIT_INIT;
        pc_q         <= ms.ms_pc;
        rf_we_q      <= ms.ms_rf_we;
        rf_waddr_q   <= ms.ms_rf_waddr;
        data_q       <= ms.ms_rf_wdata;
        csr_re_q     <= ms.ms_csr_re;
        csr_we_q     <= ms.ms_csr_we;
        csr_num_q    <= ms.ms_csr_num;
        csr_wmask_q  <= ms.ms_csr_wmask;
        csr_wvalue_q <= ms.ms_csr_wvalue;
        badv_q       <= ms.ms_badv;
        exc_q        <= ms.ms_exc;
        ertn_q       <= ms.ms_ertn;
      end
    end
  end

  // Exception cause encoding: lowest set bit of the cause vector wins.
  always_comb begin
    wb_ecode    = 6'h00;
    wb_esubcode = 9'd0;
    badv_sel    = 1'b0;
    if (wb_ex) begin
      if (exc_q[0]) begin
        wb_ecode = 6'h00;
      end else if (exc_q[1]) begin
        wb_ecode = 6'h08;
        badv_sel = 1'b1;
      end else if (exc_q[2]) begin
        wb_ecode    = 6'h08;
        wb_esubcode = 9'd1;
        badv_sel    = 1'b1;
      end else if (exc_q[3]) begin
        wb_ecode = 6'h09;
        badv_sel = 1'b1;
      end else if (exc_q[4]) begin
        wb_ecode = 6'h0B;
      end else if (exc_q[5]) begin
        wb_ecode = 6'h0C;
      end else if (exc_q[6]) begin
        wb_ecode = 6'h0D;
      end else begin
        wb_ecode = 6'h0E;
      end
    end
  end

  assign wb_badv = badv_sel ? badv_q : 32'd0;
  assign wb_pc   = pc_q;

  // With zero latency the CSR file answers combinationally during READY.
  assign ws_rf_wdata    = (ws_valid & csr_re_q & CSR_DIRECT) ? csr_rvalue : data_q;
  assign ws_rf_waddr    = rf_waddr_q;
  assign ws_rf_we       = ws_valid & rf_we_q & exc_none;
  assign ws_fwd_pending = ws_valid & csr_re_q & ~ready;

  assign csr_re     = ws_valid & csr_re_q;
  assign csr_num    = csr_num_q;
  assign csr_we     = ready & csr_we_q & exc_none & ~ertn_q;
  assign csr_wmask  = csr_wmask_q;
  assign csr_wvalue = csr_wvalue_q;

  assign retire_cnt        = retire_q;
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{ws_rf_we & ready}};
  assign debug_wb_rf_wnum  = ws_rf_waddr;
  assign debug_wb_rf_wdata = ws_rf_wdata;

endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 SHALL have parameter CSR_LAT, default 0, meaning CSR read latency in cycles (legal range 0..3).
REQ-002 SHALL have parameter CNT_W, default 32, meaning retire-counter width.
REQ-003 SHALL have ports: clk in 1, clock; resetn in 1, reset, synchronous, active-low.
REQ-004 SHALL have ports: ms2ws_valid in 1, MEM entry valid; ws_allowin out 1, WB can accept.
REQ-005 SHALL have ports: ms_pc in 32; ms_rf_we in 1; ms_rf_waddr in 5; ms_rf_wdata in 32; ms_csr_re in 1.
REQ-006 SHALL have ports: ms_csr_we in 1; ms_csr_num in 14; ms_csr_wmask in 32; ms_csr_wvalue in 32; ms_badv in 32.
REQ-007 SHALL have ports: ms_exc in 8, cause vector {IPE,INE,BRK,SYS,ALE,ADEM,ADEF,INT} (bit7..bit0); ms_ertn in 1.
REQ-008 SHALL have ports: csr_re out 1; csr_num out 14; csr_rvalue in 32; csr_we out 1; csr_wmask out 32; csr_wvalue out 32.
REQ-009 SHALL have ports: wb_ex out 1; ertn_flush out 1; wb_pc out 32; wb_ecode out 6; wb_esubcode out 9; wb_badv out 32.
REQ-010 SHALL have ports: ws_rf_we out 1; ws_rf_waddr out 5; ws_rf_wdata out 32; ws_fwd_pending out 1, WB data not yet valid.
REQ-011 SHALL have ports: retire_cnt out CNT_W; debug_wb_pc out 32; debug_wb_rf_we out 4; debug_wb_rf_wnum out 5; debug_wb_rf_wdata out 32.

Function
REQ-012 SHALL implement FSM states EMPTY, WAIT, READY; ws_valid = (state != EMPTY).
REQ-013 SHALL accept an entry when ms2ws_valid & ws_allowin; ws_allowin = (state==EMPTY | state==READY) & ~wb_ex & ~ertn_flush.
REQ-014 SHALL on accept latch all ms_* fields; next state WAIT when ms_csr_re & (ms_exc==0) & CSR_LAT>0, else READY.
REQ-015 SHALL in WAIT count down from CSR_LAT-1 to 0 and move to READY in the cycle after the count reaches 0 (CSR_LAT cycles in WAIT total).
REQ-016 SHALL hold csr_re and csr_num stable for the whole entry; csr_rvalue is sampled into the data register on the last WAIT cycle (CSR_LAT>0) or used directly in READY (CSR_LAT=0).
REQ-017 SHALL commit an entry in exactly one READY cycle; without a new accept in that cycle the next state is EMPTY.
REQ-018 SHALL give ws_rf_wdata = csr result when csr_re, else latched ms_rf_wdata.
REQ-019 SHALL drive ws_rf_we = ws_valid & rf_we & (exc==0), and ws_fwd_pending = ws_valid & csr_re & (state!=READY).
REQ-020 SHALL drive csr_we = READY & latched csr_we & (exc==0) & ~ertn; csr_wmask/csr_wvalue = latched values.
REQ-021 SHALL assert wb_ex = READY & (exc!=0) for one cycle; ertn_flush = READY & ertn & (exc==0).
REQ-022 SHALL encode wb_ecode/wb_esubcode with lowest bit index highest priority: INT 0x00/0; ADEF 0x08/0; ADEM 0x08/1; ALE 0x09/0; SYS 0x0B/0; BRK 0x0C/0; INE 0x0D/0; IPE 0x0E/0; all zero when wb_ex=0.
REQ-023 SHALL drive wb_badv = latched ms_badv when the winning cause is ADEF/ADEM/ALE, else 0; wb_pc = latched pc.
REQ-024 SHALL on wb_ex or ertn_flush go to EMPTY next cycle and discard any ms2ws_valid in that cycle.
REQ-025 SHALL increment retire_cnt by 1 on each READY cycle with exc==0 (ertn included), wrapping modulo 2^CNT_W.
REQ-026 SHALL drive debug_wb_rf_we = {4{ws_rf_we & READY}}, debug_wb_pc = wb_pc, debug_wb_rf_wnum/debug_wb_rf_wdata = ws_rf_waddr/ws_rf_wdata.
REQ-027 SHALL accept a new entry in the same cycle as a non-flushing commit (back-to-back throughput 1/cycle when CSR_LAT=0 or csr_re=0).

Reset
REQ-028 SHALL on resetn=0 at a clk edge force state EMPTY, retire_cnt 0, all latched fields 0, including mid-WAIT.
REQ-029 SHALL during and after reset drive all outputs 0 except ws_allowin=1.

Verification
REQ-030 Back-to-back: 3 ALU entries (rf_we=1, waddr 1..3, wdata 0x11/0x22/0x33), CSR_LAT=0 -> 3 consecutive debug_wb_rf_we=0xF, retire_cnt=3.
REQ-031 CSR read, CSR_LAT=2, csr_rvalue=0xABCD0000 -> ws_allowin=0, ws_fwd_pending=1 for 2 cycles; commit wdata 0xABCD0000.
REQ-032 ms_exc=0x0C (ADEM+ALE), badv=0x1003 -> wb_ex 1 cycle, ecode 0x08, esubcode 1, wb_badv 0x1003, rf/csr writes suppressed, retire_cnt unchanged.
REQ-033 ertn with ms_csr_we=1, next entry offered during commit -> ertn_flush 1 cycle, csr_we=0, next entry discarded, state EMPTY.
REQ-034 resetn=0 mid-WAIT (CSR_LAT=3, cycle 2) -> next cycle state EMPTY, all outputs 0, ws_allowin=1; CNT_W=4 with 17 commits -> retire_cnt=1.
